bck_ctrl_pipe: RTL and testbench
================================

Name:
bck_ctrl_pipe

Overview:
Parametrised backward-extension control pipeline for the SMEM engine, and the successor of the fixed three-stage, globally-stalled back-control chain. Each token carries read_num, status and read address. The pipeline fetches the interval entry from curr storage, or takes the pending curr entry on a last-one-read bypass. It then computes backward k/l and issues the occurrence-table memory request. A global stall is replaced by per-stage valid/ready backpressure, and pipeline depth is configurable.

Parameters:
READ_NUM_WIDTH, 10, read index width
ADDR_W, 7, curr/mem storage address width
DATA_W, 64, interval word width (x0, x1, x2, info)
DEPTH, 3, register stages from intake to output, minimum 2
MEM_ADDR_W, 42, memory request address width
ADDR_SHIFT, 7, log2 of BWT positions per cache line

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  token offered
in_ready  out  1  token accepted when in_valid and in_ready are both high
in_read_num  in  READ_NUM_WIDTH  read id
in_status  in  6  one-hot status
in_rd_addr  in  ADDR_W  curr storage read address
in_last_one_read  in  1  use in_curr instead of storage
in_curr  in  4*DATA_W  pending curr entry {info, x2, x1, x0}
rd_req  out  1  storage read strobe
rd_addr  out  ADDR_W  storage read address
rd_data  in  4*DATA_W  storage data, valid exactly 1 cycle after rd_req
out_valid  out  1  output token valid
out_ready  in  1  downstream accepts
out_read_num  out  READ_NUM_WIDTH  read id
out_status  out  6  status
out_p  out  4*DATA_W  selected interval entry
out_k  out  DATA_W  backward k
out_l  out  DATA_W  backward l
req_valid  out  1  memory request valid, qualified by out_valid and out_ready
req_addr_k  out  MEM_ADDR_W  cache-line address of k
req_addr_l  out  MEM_ADDR_W  cache-line address of l
finish_pulse  out  1  one-cycle pulse when a BCK_END token is accepted downstream
occupancy  out  log2(DEPTH)+1  number of valid stages

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: all stage valids 0, the hold-valid flag 0, and every output 0. Reset mid-operation drops in-flight tokens and any outstanding rd_data.
- Status encoding: BUBBLE=000000, BCK_INI=001000, BCK_RUN=010000, BCK_END=100000. Forward codes and non-one-hot values are treated as BUBBLE.
- Intake: BUBBLE tokens are consumed (in_ready=1) and not stored.
- Stage advance rule: S[i] loads when it is empty or S[i] itself advances. in_ready = !S0.valid || S0 advances. S[DEPTH-1] advances on out_ready.
- Read issue: rd_req=1 in the cycle S0 advances into S1 with status INI or RUN and last_one_read=0. rd_addr = S0.rd_addr.
- S1 data capture: in the cycle after loading, rd_data is valid.
  - If S1 advances that cycle, rd_data is forwarded directly.
  - Otherwise rd_data is latched into a hold register and hold_v is set. Later forwarding uses the hold register, and hold_v clears on advance.
  - Selection: p = last_one_read ? captured in_curr : (hold_v ? hold : rd_data).
- BCK_END: p=0, no rd_req, no request.
- Middle stages S2..S[DEPTH-2]: plain elastic slices; payload unchanged.
- Last stage load:
  - k = p.x0 - 1 and l = k + p.x2, both modulo 2^DATA_W.
  - req_addr_k = k[MEM_ADDR_W+ADDR_SHIFT-1:ADDR_SHIFT]; req_addr_l likewise from l.
  - req_valid = out_valid && out_status is INI or RUN.
- Latency and throughput: without backpressure, a token accepted at cycle t produces out_valid at t+DEPTH. Throughput is 1 token/cycle. No token is lost or duplicated under any out_ready pattern.
- Simultaneous events: when the output drains and intake accepts in the same cycle, occupancy is unchanged.
- finish_pulse=1 exactly in cycles with out_valid && out_ready && out_status==BCK_END.
- Output hold: outputs stay stable while out_valid && !out_ready.

Decomposition:
- Shared package bck_pkg:
  - status localparams (BUBBLE, BCK_INI, BCK_RUN, BCK_END);
  - default widths;
  - token struct {read_num, status, rd_addr, last_one_read, p}.
- Sub-module bck_pipe_slice: one elastic register slice with valid/ready and a payload of parameterised width. It is instantiated via generate for S2..S[DEPTH-2] and reused for S0.
- The S1 capture/hold logic and the last-stage k/l logic stay in bck_ctrl_pipe.

Test Plan:
1. DEPTH=3, out_ready=1. At cycle 0 send RUN, read_num=5, rd_addr=9, rd_data x0=100, x2=20, one cycle after rd_req -> out_valid at cycle 3 with k=99, l=119, req_addr_k=0, req_valid=1.
2. Last-one-read: in_last_one_read=1, in_curr x0=0x1000, x2=0x80 -> no rd_req; out k=0xFFF, l=0x107F, req_addr_k=0x1F, req_addr_l=0x20.
3. Backpressure: hold out_ready=0 for 10 cycles while streaming 8 RUN tokens -> in_ready falls after DEPTH tokens, occupancy=3, the hold register keeps rd_data, and after release all 8 emerge in order with correct p.
4. Bubbles: alternate BUBBLE/RUN for 6 tokens -> exactly 3 outputs, no rd_req for bubbles.
5. BCK_END token, read_num=1023 -> no rd_req; out_p=0; req_valid=0; finish_pulse a single cycle on the handshake.
6. Assert rst with 2 tokens in flight and one rd_data pending -> next cycle out_valid=0, occupancy=0, and a new token then yields correct latency DEPTH.

Source files
------------

// File: rtl/bck_pkg.sv
// Shared status codes, default widths and token layout for the backward-extension
// control pipeline.
package bck_pkg;

  localparam logic [5:0] BUBBLE  = 6'b000000;
  localparam logic [5:0] BCK_INI = 6'b001000;
  localparam logic [5:0] BCK_RUN = 6'b010000;
  localparam logic [5:0] BCK_END = 6'b100000;

  localparam int READ_NUM_WIDTH_DEF = 10;
  localparam int ADDR_W_DEF         = 7;
  localparam int DATA_W_DEF         = 64;
  localparam int DEPTH_DEF          = 3;
  localparam int MEM_ADDR_W_DEF     = 42;
  localparam int ADDR_SHIFT_DEF     = 7;

  // Default-width token; the top re-declares the same layout with its own parameters.
  typedef struct packed {
    logic [READ_NUM_WIDTH_DEF-1:0] read_num;
    logic [5:0]                    status;
    logic [ADDR_W_DEF-1:0]         rd_addr;
    logic                          last_one_read;
    logic [4*DATA_W_DEF-1:0]       p;
  } bck_token_t;

  // Anything other than the three backward codes (forward codes, non-one-hot) is a bubble.
  function automatic logic [5:0] norm_status(input logic [5:0] s);
    return (s == BCK_INI || s == BCK_RUN || s == BCK_END) ? s : BUBBLE;
  endfunction

  function automatic logic needs_read(input logic [5:0] s, input logic lor);
    return (s == BCK_INI || s == BCK_RUN) && !lor;
  endfunction

endpackage

// File: rtl/bck_pipe_slice.sv
// One elastic register slice: registered valid and payload, ready passed upstream
// combinationally so a full chain still moves one token per cycle.
module bck_pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/bck_ctrl_pipe.sv
// Backward-extension control pipeline: fetch interval entry (or bypass), compute
// backward k/l and the occurrence-table cache-line addresses, with valid/ready flow.
module bck_ctrl_pipe
  import bck_pkg::*;
#(
  parameter int READ_NUM_WIDTH = READ_NUM_WIDTH_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int DEPTH          = DEPTH_DEF,
  parameter int MEM_ADDR_W     = MEM_ADDR_W_DEF,
  parameter int ADDR_SHIFT     = ADDR_SHIFT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [READ_NUM_WIDTH-1:0] in_read_num,
  input  logic [5:0]                in_status,
  input  logic [ADDR_W-1:0]         in_rd_addr,
  input  logic                      in_last_one_read,
  input  logic [4*DATA_W-1:0]       in_curr,
  output logic                      rd_req,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [4*DATA_W-1:0]       rd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [READ_NUM_WIDTH-1:0] out_read_num,
  output logic [5:0]                out_status,
  output logic [4*DATA_W-1:0]       out_p,
  output logic [DATA_W-1:0]         out_k,
  output logic [DATA_W-1:0]         out_l,
  output logic                      req_valid,
  output logic [MEM_ADDR_W-1:0]     req_addr_k,
  output logic [MEM_ADDR_W-1:0]     req_addr_l,
  output logic                      finish_pulse,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int NMID  = (DEPTH >= 3) ? DEPTH - 3 : 0;
  localparam int PW    = 4 * DATA_W;

  typedef struct packed {
    logic [READ_NUM_WIDTH-1:0] read_num;
    logic [5:0]                status;
    logic [ADDR_W-1:0]         rd_addr;
    logic                      last_one_read;
    logic [PW-1:0]             p;
  } tok_t;

  localparam int TW = $bits(tok_t);

  logic [5:0] in_st;
  tok_t       in_tok, s0_tok;
  logic       s0_v, s0_in_ready, s1_ready;

  assign in_st = norm_status(in_status);

  always_comb begin
    in_tok               = '0;
    in_tok.read_num      = in_read_num;
    in_tok.status        = in_st;
    in_tok.rd_addr       = in_rd_addr;
    in_tok.last_one_read = in_last_one_read;
    in_tok.p             = (in_last_one_read && in_st != BCK_END) ? in_curr : '0;
  end

  // Bubbles see in_ready but never enter S0.
  bck_pipe_slice #(.W(TW)) u_s0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid && in_st != BUBBLE),
    .in_ready  (s0_in_ready),
    .in_data   (in_tok),
    .out_valid (s0_v),
    .out_ready (s1_ready),
    .out_data  (s0_tok)
  );

  assign in_ready = !rst && s0_in_ready;
  assign rd_addr  = s0_tok.rd_addr;
  assign rd_req   = s0_v && s1_ready && needs_read(s0_tok.status, s0_tok.last_one_read);

  logic          s1_v, s1_fresh, hold_v, s1_adv;
  tok_t          s1_tok, s1_out;
  logic [PW-1:0] hold;
  logic          c_v   [0:NMID];
  logic          c_rdy [0:NMID];
  tok_t          c_d   [0:NMID];

  assign s1_ready = !s1_v || c_rdy[0];
  assign s1_adv   = s1_v && c_rdy[0];

  // rd_data is only valid in the cycle after rd_req; if S1 cannot move on then,
  // park it in hold until it does.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s1_tok   <= '0;
      s1_fresh <= 1'b0;
      hold_v   <= 1'b0;
      hold     <= '0;
    end else begin
      s1_fresh <= rd_req;
      if (s1_ready) begin
        s1_v <= s0_v;
        if (s0_v) s1_tok <= s0_tok;
      end
      if (s1_adv) begin
        hold_v <= 1'b0;
      end else if (s1_fresh) begin
        hold_v <= 1'b1;
        hold   <= rd_data;
      end
    end
  end

  always_comb begin
    s1_out = s1_tok;
    if (needs_read(s1_tok.status, s1_tok.last_one_read))
      s1_out.p = hold_v ? hold : rd_data;
  end

  assign c_v[0] = s1_v;
  assign c_d[0] = s1_out;

  for (genvar j = 0; j < NMID; j++) begin : g_mid
    bck_pipe_slice #(.W(TW)) u_mid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (c_v[j]),
      .in_ready  (c_rdy[j]),
      .in_data   (c_d[j]),
      .out_valid (c_v[j+1]),
      .out_ready (c_rdy[j+1]),
      .out_data  (c_d[j+1])
    );
  end

  tok_t              tail_tok, o_tok;
  logic              o_v;
  logic [DATA_W-1:0] k_nxt, l_nxt, o_k, o_l;

  assign tail_tok = c_d[NMID];
  assign k_nxt    = tail_tok.p[DATA_W-1:0] - DATA_W'(1);
  assign l_nxt    = k_nxt + tail_tok.p[3*DATA_W-1:2*DATA_W];

  if (DEPTH >= 3) begin : g_last
    logic              lv;
    tok_t              ltok;
    logic [DATA_W-1:0] lk, ll;

    assign c_rdy[NMID] = !lv || out_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        lv   <= 1'b0;
        ltok <= '0;
        lk   <= '0;
        ll   <= '0;
      end else if (c_rdy[NMID]) begin
        lv <= c_v[NMID];
        if (c_v[NMID]) begin
          ltok <= c_d[NMID];
          lk   <= k_nxt;
          ll   <= l_nxt;
        end
      end
    end

    assign o_v   = lv;
    assign o_tok = ltok;
    assign o_k   = lk;
    assign o_l   = ll;
  end else begin : g_direct
    // Two-stage build: S1 is the output stage, k/l formed straight from its entry.
    assign c_rdy[0] = out_ready;
    assign o_v      = c_v[0];
    assign o_tok    = c_v[0] ? c_d[0] : '0;
    assign o_k      = c_v[0] ? k_nxt : '0;
    assign o_l      = c_v[0] ? l_nxt : '0;
  end

  assign out_valid    = o_v;
  assign out_read_num = o_tok.read_num;
  assign out_status   = o_tok.status;
  assign out_p        = o_tok.p;
  assign out_k        = o_k;
  assign out_l        = o_l;
  assign req_addr_k   = o_k[MEM_ADDR_W+ADDR_SHIFT-1:ADDR_SHIFT];
  assign req_addr_l   = o_l[MEM_ADDR_W+ADDR_SHIFT-1:ADDR_SHIFT];
  assign req_valid    = o_v && (o_tok.status == BCK_INI || o_tok.status == BCK_RUN);
  assign finish_pulse = o_v && out_ready && (o_tok.status == BCK_END);

  logic unused_tok_bits;
  assign unused_tok_bits = ^{o_tok.rd_addr, o_tok.last_one_read};

  always_comb begin
    occupancy = OCC_W'(s0_v) + OCC_W'(s1_v);
    for (int j = 1; j <= NMID; j++) occupancy = occupancy + OCC_W'(c_v[j]);
    if (DEPTH >= 3) occupancy = occupancy + OCC_W'(o_v);
  end

endmodule

// File: tb/tb_bck_ctrl_pipe.sv
// Directed bench for bck_ctrl_pipe (DEPTH=3) with a storage model and an in-order
// scoreboard on the output handshake.
module tb_bck_ctrl_pipe;
  import bck_pkg::*;

  localparam int DEPTH = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [9:0]   in_read_num = '0;
  logic [5:0]   in_status = '0;
  logic [6:0]   in_rd_addr = '0;
  logic         in_last_one_read = 1'b0;
  logic [255:0] in_curr = '0;
  logic         rd_req;
  logic [6:0]   rd_addr;
  logic [255:0] rd_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [9:0]   out_read_num;
  logic [5:0]   out_status;
  logic [255:0] out_p;
  logic [63:0]  out_k, out_l;
  logic         req_valid;
  logic [41:0]  req_addr_k, req_addr_l;
  logic         finish_pulse;
  logic [2:0]   occupancy;

  always #5 clk = ~clk;

  bck_ctrl_pipe #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_read_num(in_read_num), .in_status(in_status), .in_rd_addr(in_rd_addr),
    .in_last_one_read(in_last_one_read), .in_curr(in_curr),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_read_num(out_read_num),
    .out_status(out_status), .out_p(out_p), .out_k(out_k), .out_l(out_l),
    .req_valid(req_valid), .req_addr_k(req_addr_k), .req_addr_l(req_addr_l),
    .finish_pulse(finish_pulse), .occupancy(occupancy)
  );

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  // storage model: answers one cycle after rd_req, junk otherwise
  logic [255:0] mem [128];
  logic [255:0] junk = {4{64'hDEAD_BEEF_0BAD_F00D}};
  logic         nreq = 1'b0;
  logic [6:0]   naddr = '0;
  int           cyc = 0;

  initial rd_data = junk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    rd_data = nreq ? mem[naddr] : junk;
  end

  typedef struct {
    logic [9:0]   rn;
    logic [5:0]   st;
    logic [255:0] p;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t         sbq[$];
  exp_t         mon_e;
  bit           free_run = 1'b1;
  int           n_acc = 0, n_out = 0, n_rdreq = 0;
  bit           stall_prev = 1'b0;
  logic [9:0]   snap_rn;
  logic [255:0] snap_p;
  logic [63:0]  snap_k, ek, el;

  always @(negedge clk) begin
    nreq  = rd_req;
    naddr = rd_addr;
    if (rd_req) n_rdreq++;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) begin
        check("hold_rn", out_read_num, snap_rn);
        check("hold_p", out_p, snap_p);
        check("hold_k", out_k, snap_k);
      end
      stall_prev = out_valid && !out_ready;
      snap_rn = out_read_num; snap_p = out_p; snap_k = out_k;
      if (out_valid && out_ready) begin
        n_out++;
        check("sb_nonempty", sbq.size() != 0, 1'b1);
        if (sbq.size() != 0) begin
          mon_e = sbq.pop_front();
          ek = mon_e.p[63:0] - 64'd1;
          el = ek + mon_e.p[191:128];
          check("out_read_num", out_read_num, mon_e.rn);
          check("out_status", out_status, mon_e.st);
          check("out_p", out_p, mon_e.p);
          check("out_k", out_k, ek);
          check("out_l", out_l, el);
          check("req_addr_k", req_addr_k, ek[48:7]);
          check("req_addr_l", req_addr_l, el[48:7]);
          check("req_valid", req_valid, mon_e.st != BCK_END);
          check("finish_pulse", finish_pulse, mon_e.st == BCK_END);
          if (mon_e.lat) check("latency", cyc - mon_e.acc, DEPTH);
        end
      end
    end
  end

  task automatic send(input logic [9:0] rn, input logic [5:0] st, input logic [6:0] addr,
                      input logic lor, input logic [255:0] curr);
    int w = 0;
    exp_t e;
    in_valid = 1'b1; in_read_num = rn; in_status = st; in_rd_addr = addr;
    in_last_one_read = lor; in_curr = curr;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("send_accept", in_ready, 1'b1);
    if (in_ready) begin
      n_acc++;
      if (st == BCK_INI || st == BCK_RUN || st == BCK_END) begin
        e.rn = rn; e.st = st; e.acc = cyc; e.lat = free_run;
        e.p = (st == BCK_END) ? 256'd0 : (lor ? curr : mem[addr]);
        sbq.push_back(e);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain_empty", sbq.size(), 0);
  endtask

  int acc0, out0, rq0;
  logic [5:0] pat [6];

  initial begin
    for (int a = 0; a < 128; a++)
      mem[a] = {64'(a), 64'(a + 1), 64'(a * 3), 64'h1000 * 64'(a) + 64'd77};
    mem[9] = {64'h9, 64'd20, 64'd0, 64'd100};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_occupancy", occupancy, 3'd0);
    check("rst_rd_req", rd_req, 1'b0);
    check("rst_out_k", out_k, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: RUN through storage
    send(10'd5, BCK_RUN, 7'd9, 1'b0, '0);
    @(negedge clk);
    check("t1_rd_req", rd_req, 1'b1);
    check("t1_rd_addr", rd_addr, 7'd9);
    @(negedge clk);
    check("t1_early_valid", out_valid, 1'b0);
    @(negedge clk);
    check("t1_out_valid", out_valid, 1'b1);
    check("t1_rn", out_read_num, 10'd5);
    check("t1_k", out_k, 64'd99);
    check("t1_l", out_l, 64'd119);
    check("t1_req_addr_k", req_addr_k, 42'd0);
    check("t1_req_valid", req_valid, 1'b1);

    // 2: last-one-read bypass
    @(posedge clk); #1;
    send(10'd6, BCK_RUN, 7'd3, 1'b1, {64'hAB, 64'h80, 64'h0, 64'h1000});
    @(negedge clk);
    check("t2_no_rd_req", rd_req, 1'b0);
    repeat (2) @(negedge clk);
    check("t2_out_valid", out_valid, 1'b1);
    check("t2_k", out_k, 64'hFFF);
    check("t2_l", out_l, 64'h107F);
    check("t2_req_addr_k", req_addr_k, 42'h1F);
    check("t2_req_addr_l", req_addr_l, 42'h20);
    drain();

    // 3: backpressure with 8 tokens
    @(posedge clk); #1;
    free_run = 1'b0;
    out_ready = 1'b0;
    acc0 = n_acc;
    fork
      for (int i = 0; i < 8; i++)
        send(10'(10 + i), (i == 0) ? BCK_INI : BCK_RUN, 7'(20 + i), 1'b0, '0);
      begin
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t3_in_ready_low", in_ready, 1'b0);
        check("t3_occupancy", occupancy, 3'd3);
        check("t3_accepted", n_acc - acc0, 3);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // 4: bubbles interleaved (plain, forward code, non-one-hot)
    @(posedge clk); #1;
    free_run = 1'b1;
    pat = '{BUBBLE, BCK_RUN, 6'b000001, BCK_RUN, 6'b011000, BCK_RUN};
    out0 = n_out; rq0 = n_rdreq;
    for (int i = 0; i < 6; i++) send(10'(200 + i), pat[i], 7'(60 + i), 1'b0, '0);
    drain();
    repeat (2) @(negedge clk);
    check("t4_outputs", n_out - out0, 3);
    check("t4_rd_reqs", n_rdreq - rq0, 3);

    // 5: BCK_END, held once at the output
    @(posedge clk); #1;
    free_run = 1'b0;
    out_ready = 1'b0;
    send(10'd1023, BCK_END, 7'd5, 1'b0, '0);
    @(negedge clk);
    check("t5_no_rd_req", rd_req, 1'b0);
    repeat (2) @(negedge clk);
    check("t5_out_valid", out_valid, 1'b1);
    check("t5_out_p", out_p, 256'd0);
    check("t5_req_valid", req_valid, 1'b0);
    check("t5_finish_stalled", finish_pulse, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("t5_finish", finish_pulse, 1'b1);
    @(negedge clk);
    check("t5_finish_single", finish_pulse, 1'b0);
    check("t5_out_drained", out_valid, 1'b0);

    // 6: reset with two tokens in flight and a read outstanding
    @(posedge clk); #1;
    free_run = 1'b1;
    send(10'd100, BCK_RUN, 7'd40, 1'b0, '0);
    send(10'd101, BCK_RUN, 7'd41, 1'b0, '0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_pending_rd", rd_req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_occupancy", occupancy, 3'd0);
    @(posedge clk); #1;
    send(10'd102, BCK_RUN, 7'd50, 1'b0, '0);
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
